// File: rtl/elastic_pipe_if.sv
// elastic_pipe_if
// Handshake bundle for the elastic pipeline register chain.
// Upstream side: in_valid, in_ready, in_data.
// Downstream side: out_valid, out_ready, out_data.
// Control and status: flush (synchronous discard), occupancy (entries held).
// The slave modport is the pipeline itself. The master modport is whoever
// drives the upstream inputs and consumes the downstream outputs.
interface elastic_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 3
);
  localparam int OCC_W = $clog2(2*STAGES+1);

  logic                  in_valid;
  logic                  in_ready;
  logic [DATA_WIDTH-1:0] in_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [DATA_WIDTH-1:0] out_data;
  logic                  flush;
  logic [OCC_W-1:0]      occupancy;

  modport master (
    output in_valid, in_data, out_ready, flush,
    input  in_ready, out_valid, out_data, occupancy
  );

  modport slave (
    input  in_valid, in_data, out_ready, flush,
    output in_ready, out_valid, out_data, occupancy
  );
endinterface

// File: rtl/elastic_pipe.sv
// elastic_pipe
// A chain of STAGES register slices joined by a valid/ready handshake.
// Each slice has two entries: a main entry (M) and a skid entry (S).
// A slice advertises ready upstream only while its skid entry is empty, so
// every ready is taken from a register and never ripples combinationally
// across slices. The chain holds up to 2*STAGES words in strict FIFO order.
// Empty main entries are refilled from the previous slice on the next edge,
// which collapses bubbles.
// Ports:
//   clk   - rising-edge clock
//   reset - asynchronous, active-high; clears all valid bits and payloads
//   bus   - elastic_pipe_if.slave carrying the in_* and out_* handshakes,
//           flush and occupancy
module elastic_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int STAGES     = 3
) (
  input  logic          clk,
  input  logic          reset,
  elastic_pipe_if.slave bus
);
  localparam int OCC_W = $clog2(2*STAGES+1);

  if (STAGES < 1) begin : gBadStages
    $error("elastic_pipe: STAGES must be at least 1");
  end

  logic [STAGES-1:0]     mValid_q, mValid_d;
  logic [STAGES-1:0]     sValid_q, sValid_d;
  logic [DATA_WIDTH-1:0] mData_q [STAGES];
  logic [DATA_WIDTH-1:0] mData_d [STAGES];
  logic [DATA_WIDTH-1:0] sData_q [STAGES];
  logic [DATA_WIDTH-1:0] sData_d [STAGES];
  logic [OCC_W-1:0]      occ_q, occ_d;

  logic [STAGES-1:0]     upValid;
  logic [STAGES-1:0]     downReady;
  logic [STAGES-1:0]     take;
  logic [STAGES-1:0]     drain;
  logic [DATA_WIDTH-1:0] upData [STAGES];
  logic                  inXfer;
  logic                  outXfer;

  // Wire each slice to its neighbours. Slice 0 is fed from the input port.
  // The last slice drains into the output port.
  for (genvar g = 0; g < STAGES; g++) begin : gLink
    if (g == 0) begin : gHead
      assign upValid[g] = bus.in_valid;
      assign upData[g]  = bus.in_data;
    end else begin : gBody
      assign upValid[g] = mValid_q[g-1];
      assign upData[g]  = mData_q[g-1];
    end
    if (g == STAGES-1) begin : gTail
      assign downReady[g] = bus.out_ready;
    end else begin : gMid
      assign downReady[g] = !sValid_q[g+1];
    end
  end

  assign take    = upValid & ~sValid_q;
  assign drain   = mValid_q & downReady;
  assign inXfer  = bus.in_valid & bus.in_ready;
  assign outXfer = bus.out_valid & bus.out_ready;

  // Per-slice next state.
  // A slice can only take a word while its skid entry is empty, so a drain
  // with a full skid never coincides with an incoming word. Flush clears the
  // valid bits after the data moves, so it overrides any transfer.
  always_comb begin
    mValid_d = mValid_q;
    sValid_d = sValid_q;
    mData_d  = mData_q;
    sData_d  = sData_q;
    for (int i = 0; i < STAGES; i++) begin
      if (drain[i] && sValid_q[i]) begin
        mData_d[i]  = sData_q[i];
        sValid_d[i] = 1'b0;
      end else if (take[i] && (!mValid_q[i] || drain[i])) begin
        mValid_d[i] = 1'b1;
        mData_d[i]  = upData[i];
      end else if (take[i]) begin
        sValid_d[i] = 1'b1;
        sData_d[i]  = upData[i];
      end else if (drain[i]) begin
        mValid_d[i] = 1'b0;
      end
    end
    if (bus.flush) begin
      mValid_d = '0;
      sValid_d = '0;
    end
  end

  // Occupancy tracks accepted minus delivered words. A simultaneous input
  // and output leaves it unchanged.
  always_comb begin
    occ_d = occ_q;
    if (bus.flush) begin
      occ_d = '0;
    end else if (inXfer && !outXfer) begin
      occ_d = occ_q + OCC_W'(1);
    end else if (outXfer && !inXfer) begin
      occ_d = occ_q - OCC_W'(1);
    end
  end

  // State registers. Reset clears the payloads as well as the valid bits, so
  // no output can be X after reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      mValid_q <= '0;
      sValid_q <= '0;
      occ_q    <= '0;
      for (int i = 0; i < STAGES; i++) begin
        mData_q[i] <= '0;
        sData_q[i] <= '0;
      end
    end else begin
      mValid_q <= mValid_d;
      sValid_q <= sValid_d;
      occ_q    <= occ_d;
      for (int i = 0; i < STAGES; i++) begin
        mData_q[i] <= mData_d[i];
        sData_q[i] <= sData_d[i];
      end
    end
  end

  // in_ready is held low while reset is asserted. Otherwise it follows the
  // registered skid-valid bit of slice 0.
  assign bus.in_ready  = !reset && !sValid_q[0];
  assign bus.out_valid = mValid_q[STAGES-1];
  assign bus.out_data  = mData_q[STAGES-1];
  assign bus.occupancy = occ_q;
endmodule

// File: tb/tb_elastic_pipe.sv
// tb_elastic_pipe
// Exercises elastic_pipe in two configurations:
//   - STAGES=3, DATA_WIDTH=32: checked against a scoreboard queue.
//   - STAGES=1, DATA_WIDTH=8: directed checks.
// Inputs are driven on the falling edge. Outputs are sampled mid-cycle.
module tb_elastic_pipe;
  logic clk = 1'b0;
  logic reset;

  always #5 clk = ~clk;

  elastic_pipe_if #(.DATA_WIDTH(32), .STAGES(3)) busA ();
  elastic_pipe_if #(.DATA_WIDTH(8),  .STAGES(1)) busB ();

  elastic_pipe #(.DATA_WIDTH(32), .STAGES(3)) dutA (
    .clk  (clk),
    .reset(reset),
    .bus  (busA)
  );

  elastic_pipe #(.DATA_WIDTH(8), .STAGES(1)) dutB (
    .clk  (clk),
    .reset(reset),
    .bus  (busB)
  );

  int          checkCount = 0;
  int          passCount  = 0;
  logic [31:0] sbQ [$];
  logic        lastInX;
  logic        lastOutX;

  // Every comparison goes through here.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checkCount++;
    if (actual === expected) passCount++;
    else $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t",
                  tag, actual, expected, $time);
  endtask

  // One clock cycle on dutA, starting and ending at a falling edge.
  // Accepted words are pushed to the scoreboard. Delivered words are popped
  // and compared. Occupancy is then checked against the scoreboard depth.
  task automatic applyStimulus(input logic iv, input logic [31:0] id,
                               input logic ordy, input logic fl);
    logic        inX;
    logic        outX;
    logic [31:0] od;
    logic [31:0] expWord;
    busA.in_valid  = iv;
    busA.in_data   = id;
    busA.out_ready = ordy;
    busA.flush     = fl;
    #1;
    inX  = iv & busA.in_ready;
    outX = busA.out_valid & ordy;
    od   = busA.out_data;
    @(posedge clk);
    if (outX) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedOut", od, 32'hFFFF_FFFF);
      end else begin
        expWord = sbQ.pop_front();
        checkOutput("outData", od, expWord);
      end
    end
    if (fl) sbQ.delete();
    else if (inX) sbQ.push_back(id);
    lastInX  = inX;
    lastOutX = outX;
    @(negedge clk);
    checkOutput("occupancy", 32'(busA.occupancy), 32'(sbQ.size()));
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int nextWord;
    int waitCycles;

    reset = 1'b1;
    busA.in_valid = 1'b0; busA.in_data = '0; busA.out_ready = 1'b0; busA.flush = 1'b0;
    busB.in_valid = 1'b0; busB.in_data = '0; busB.out_ready = 1'b0; busB.flush = 1'b0;

    // Reset state.
    #2;
    checkOutput("rstInReady",  32'(busA.in_ready),  0);
    checkOutput("rstOutValid", 32'(busA.out_valid), 0);
    checkOutput("rstOcc",      32'(busA.occupancy), 0);
    checkOutput("rstOutData",  busA.out_data,       0);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checkOutput("inReadyAfterReset", 32'(busA.in_ready), 1);
    @(negedge clk);

    // Latency: a single word reaches the output after STAGES edges.
    applyStimulus(1'b1, 32'hDEAD0001, 1'b1, 1'b0);
    checkOutput("latE0Valid", 32'(busA.out_valid), 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("latE1Valid", 32'(busA.out_valid), 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("latE2Valid", 32'(busA.out_valid), 1);
    checkOutput("latE2Data",  busA.out_data, 32'hDEAD0001);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("latDelivered", 32'(lastOutX), 1);
    checkOutput("latE3Valid",   32'(busA.out_valid), 0);

    // Streaming at full rate.
    for (int k = 1; k <= 100; k++) begin
      applyStimulus(1'b1, 32'(k), 1'b1, 1'b0);
      checkOutput("streamInReady", 32'(lastInX), 1);
      if (k >= 4) checkOutput("streamNoGap", 32'(lastOutX), 1);
    end
    repeat (3) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("streamDrained", 32'(sbQ.size()), 0);

    // Backpressure: the chain holds exactly 2*STAGES words.
    nextWord = 1;
    for (int k = 0; k < 10; k++) begin
      applyStimulus(1'b1, 32'(nextWord), 1'b0, 1'b0);
      if (lastInX) nextWord++;
    end
    checkOutput("fillAccepted", 32'(nextWord - 1), 6);
    checkOutput("fillInReady",  32'(busA.in_ready), 0);
    waitCycles = 0;
    do begin
      applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
      waitCycles++;
    end while (!busA.in_ready && waitCycles < 8);
    checkOutput("fillReadyReturns", 32'(busA.in_ready), 1);
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("fillDrained", 32'(sbQ.size()), 0);

    // Random stalls on both sides.
    repeat (10000) begin
      applyStimulus(1'($urandom_range(0, 1)), $urandom, 1'($urandom_range(0, 1)), 1'b0);
    end
    repeat (8) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("randomDrained", 32'(sbQ.size()), 0);

    // Flush on an edge that carries both an input and an output transfer.
    for (int k = 0; k < 4; k++) applyStimulus(1'b1, 32'h100 + 32'(k), 1'b0, 1'b0);
    checkOutput("preFlushOcc", 32'(busA.occupancy), 4);
    applyStimulus(1'b1, 32'hBAD0BAD0, 1'b1, 1'b1);
    checkOutput("flushInXfer",   32'(lastInX),  1);
    checkOutput("flushOutXfer",  32'(lastOutX), 1);
    checkOutput("flushOutValid", 32'(busA.out_valid), 0);
    checkOutput("flushInReady",  32'(busA.in_ready),  1);
    applyStimulus(1'b1, 32'h200, 1'b1, 1'b0);
    repeat (4) applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("postFlushDrained", 32'(sbQ.size()), 0);

    // Asynchronous reset in the middle of a cycle.
    for (int k = 0; k < 5; k++) applyStimulus(1'b1, 32'h300 + 32'(k), 1'b0, 1'b0);
    checkOutput("preResetOcc", 32'(busA.occupancy), 5);
    busA.in_valid = 1'b0;
    #2;
    reset = 1'b1;
    #1;
    checkOutput("asyncRstOutValid", 32'(busA.out_valid), 0);
    checkOutput("asyncRstOcc",      32'(busA.occupancy), 0);
    checkOutput("asyncRstOutData",  busA.out_data,       0);
    checkOutput("asyncRstInReady",  32'(busA.in_ready),  0);
    sbQ.delete();
    @(negedge clk);
    reset = 1'b0;
    applyStimulus(1'b1, 32'hA5, 1'b1, 1'b0);
    checkOutput("a5Accepted", 32'(lastInX), 1);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("a5E1Valid", 32'(busA.out_valid), 0);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("a5E2Valid", 32'(busA.out_valid), 1);
    checkOutput("a5E2Data",  busA.out_data, 32'hA5);
    applyStimulus(1'b0, 32'h0, 1'b1, 1'b0);
    checkOutput("a5Drained", 32'(sbQ.size()), 0);

    // Single-slice, 8-bit configuration.
    busB.in_valid = 1'b1; busB.in_data = 8'h5A; busB.out_ready = 1'b0;
    @(posedge clk); @(negedge clk);
    busB.in_data = 8'h3C;
    checkOutput("bE0Valid",   32'(busB.out_valid), 1);
    checkOutput("bE0Data",    32'(busB.out_data),  32'h5A);
    checkOutput("bE0Occ",     32'(busB.occupancy), 1);
    checkOutput("bE0InReady", 32'(busB.in_ready),  1);
    @(posedge clk); @(negedge clk);
    busB.in_valid = 1'b0;
    checkOutput("bFullInReady", 32'(busB.in_ready),  0);
    checkOutput("bFullOcc",     32'(busB.occupancy), 2);
    checkOutput("bFullData",    32'(busB.out_data),  32'h5A);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("bRstOutValid", 32'(busB.out_valid), 0);
    checkOutput("bRstOcc",      32'(busB.occupancy), 0);
    checkOutput("bRstOutData",  32'(busB.out_data),  0);
    @(negedge clk);
    reset = 1'b0;
    busB.in_valid = 1'b1; busB.in_data = 8'hA5;
    @(posedge clk); @(negedge clk);
    busB.in_valid = 1'b0; busB.out_ready = 1'b1;
    checkOutput("bA5Valid", 32'(busB.out_valid), 1);
    checkOutput("bA5Data",  32'(busB.out_data),  32'hA5);
    checkOutput("bA5Occ",   32'(busB.occupancy), 1);
    @(posedge clk); @(negedge clk);
    checkOutput("bDoneValid", 32'(busB.out_valid), 0);
    checkOutput("bDoneOcc",   32'(busB.occupancy), 0);

    $display("%0d/%0d checks passed", passCount, checkCount);
    $finish;
  end
endmodule
